// File: rtl/snd_dma_pkg.sv
// Shared constants and address packing for the sound DMA address generator.
// Addresses are word addresses: byte address bits [21:1].
package snd_dma_pkg;
   localparam int ADDR_W      = 21;
   localparam int FIFO_DEPTH  = 4;
   localparam int SREQ_THRESH = 2;
   localparam int LVL_W       = 3;

   localparam logic [3:0] RA_START_HI = 4'd0;
   localparam logic [3:0] RA_START_MI = 4'd1;
   localparam logic [3:0] RA_START_LO = 4'd2;
   localparam logic [3:0] RA_END_HI   = 4'd3;
   localparam logic [3:0] RA_END_MI   = 4'd4;
   localparam logic [3:0] RA_END_LO   = 4'd5;
   localparam logic [3:0] RA_CNT_HI   = 4'd6;
   localparam logic [3:0] RA_CNT_MI   = 4'd7;
   localparam logic [3:0] RA_CNT_LO   = 4'd8;

   // Byte lanes of a word address as the CPU sees them; unused bits read 0.
   function automatic logic [7:0] addr_byte(input logic [ADDR_W-1:0] a, input logic [1:0] lane);
      logic [7:0] b;
      case (lane)
         2'd0:    b = {2'b00, a[20:15]};
         2'd1:    b = a[14:7];
         default: b = {a[6:0], 1'b0};
      endcase
      return b;
   endfunction
endpackage

// File: rtl/snd_fifo_level.sv
// Tracks buffered sound words, raises the DMA request and flags DAC starvation.
module snd_fifo_level
   import snd_dma_pkg::*;
(
   input  logic             clk,
   input  logic             resb,
   input  logic             i_sndon,
   input  logic             i_clr,
   input  logic             i_sndclk_en,
   input  logic             i_sample_tick,
   output logic [LVL_W-1:0] o_fifo_level,
   output logic             o_sreq,
   output logic             o_underrun
);
   logic [LVL_W-1:0] r_level;
   logic [LVL_W-1:0] w_level_nxt;
   logic             r_sreq;
   logic             r_underrun;
   logic             w_starve;

   always_comb begin
      w_level_nxt = r_level;
      if (i_sndclk_en && !i_sample_tick && r_level != LVL_W'(FIFO_DEPTH))
         w_level_nxt = r_level + LVL_W'(1);
      else if (i_sample_tick && !i_sndclk_en && r_level != '0)
         w_level_nxt = r_level - LVL_W'(1);
   end

   assign w_starve = i_sndon && i_sample_tick && !i_sndclk_en && (r_level == '0);

   always_ff @(posedge clk) begin
      if (!resb) begin
         r_level    <= '0;
         r_sreq     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         // Request decision uses the level before this edge's update.
         r_sreq <= i_sndon && (r_level <= LVL_W'(SREQ_THRESH));
         if (!i_sndon || i_clr)
            r_level <= '0;
         else
            r_level <= w_level_nxt;
         if (i_clr)
            r_underrun <= 1'b0;
         else if (w_starve)
            r_underrun <= 1'b1;
      end
   end

   assign o_fifo_level = r_level;
   assign o_sreq       = r_sreq;
   assign o_underrun   = r_underrun;
endmodule

// File: rtl/snd_dma_addr.sv
// Sound DMA address generator: CPU-visible shadow start/end registers, a frame
// address counter reloaded at frame end, and the word-buffer level tracker.
module snd_dma_addr
   import snd_dma_pkg::*;
(
   input  logic              clk,
   input  logic              resb,
   input  logic              reg_we,
   input  logic [3:0]        reg_addr,
   input  logic [7:0]        reg_din,
   output logic [7:0]        reg_dout,
   input  logic              sndon,
   input  logic              sndclk_en,
   input  logic              sload,
   input  logic              sample_tick,
   output logic [ADDR_W-1:0] snd,
   output logic [ADDR_W-1:0] sft,
   output logic              sreq,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              underrun
);
   logic [ADDR_W-1:0] r_sh_start;
   logic [ADDR_W-1:0] r_sh_end;
   logic [ADDR_W-1:0] r_act_start;
   logic [ADDR_W-1:0] r_act_end;
   logic [ADDR_W-1:0] r_snd;
   logic              r_sndon_d;
   logic              w_rise;

   assign w_rise = sndon && !r_sndon_d;

   always_ff @(posedge clk) begin
      if (!resb) begin
         r_sh_start  <= '0;
         r_sh_end    <= '0;
         r_act_start <= '0;
         r_act_end   <= '0;
         r_snd       <= '0;
         r_sndon_d   <= 1'b0;
      end else begin
         r_sndon_d <= sndon;
         if (reg_we) begin
            case (reg_addr)
               RA_START_HI: r_sh_start[20:15] <= reg_din[5:0];
               RA_START_MI: r_sh_start[14:7]  <= reg_din;
               RA_START_LO: r_sh_start[6:0]   <= reg_din[7:1];
               RA_END_HI:   r_sh_end[20:15]   <= reg_din[5:0];
               RA_END_MI:   r_sh_end[14:7]    <= reg_din;
               RA_END_LO:   r_sh_end[6:0]     <= reg_din[7:1];
               default: ;
            endcase
         end
         if (w_rise) begin
            r_snd       <= r_sh_start;
            r_act_start <= r_sh_start;
            r_act_end   <= r_sh_end;
         end else if (sndon) begin
            // Reload restarts from the frame's own start; shadows arm the next frame.
            if (sload) begin
               r_snd       <= r_act_start;
               r_act_start <= r_sh_start;
               r_act_end   <= r_sh_end;
            end else if (sndclk_en) begin
               r_snd <= r_snd + ADDR_W'(1);
            end
         end
      end
   end

   always_comb begin
      reg_dout = 8'h00;
      case (reg_addr)
         RA_START_HI: reg_dout = addr_byte(r_sh_start, 2'd0);
         RA_START_MI: reg_dout = addr_byte(r_sh_start, 2'd1);
         RA_START_LO: reg_dout = addr_byte(r_sh_start, 2'd2);
         RA_END_HI:   reg_dout = addr_byte(r_sh_end, 2'd0);
         RA_END_MI:   reg_dout = addr_byte(r_sh_end, 2'd1);
         RA_END_LO:   reg_dout = addr_byte(r_sh_end, 2'd2);
         RA_CNT_HI:   reg_dout = addr_byte(r_snd, 2'd0);
         RA_CNT_MI:   reg_dout = addr_byte(r_snd, 2'd1);
         RA_CNT_LO:   reg_dout = addr_byte(r_snd, 2'd2);
         default:     reg_dout = 8'h00;
      endcase
   end

   snd_fifo_level u_fifo_level (
      .clk           (clk),
      .resb          (resb),
      .i_sndon       (sndon),
      .i_clr         (w_rise),
      .i_sndclk_en   (sndclk_en),
      .i_sample_tick (sample_tick),
      .o_fifo_level  (fifo_level),
      .o_sreq        (sreq),
      .o_underrun    (underrun)
   );

   assign snd = r_snd;
   assign sft = r_act_end;
endmodule

// File: tb/tb_snd_dma_addr.sv
// Scoreboard bench for snd_dma_addr: a byte-level reference model predicts every
// post-edge output; a monitor pops and compares after each rising edge.
module tb_snd_dma_addr;
   logic        clk = 1'b0;
   logic        resb, reg_we, sndon, sndclk_en, sload, sample_tick;
   logic [3:0]  reg_addr;
   logic [7:0]  reg_din, reg_dout;
   logic [20:0] snd, sft;
   logic        sreq, underrun;
   logic [2:0]  fifo_level;

   snd_dma_addr dut (
      .clk(clk), .resb(resb), .reg_we(reg_we), .reg_addr(reg_addr), .reg_din(reg_din),
      .reg_dout(reg_dout), .sndon(sndon), .sndclk_en(sndclk_en), .sload(sload),
      .sample_tick(sample_tick), .snd(snd), .sft(sft), .sreq(sreq),
      .fifo_level(fifo_level), .underrun(underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int snd; int sft; int sreq; int lvl; int und; int dout;
   } exp_t;
   exp_t q[$];

   int n_pass = 0;
   int n_total = 0;

   // Reference model state: raw register bytes and integer addresses.
   int m_sh[6];
   int m_snd, m_as, m_ae, m_lvl, m_sreq, m_und, m_on_d;

   function automatic void chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endfunction

   function automatic int byte_addr(input int hi, input int mi, input int lo);
      return ((hi & 'h3F) * 65536 + mi * 256 + (lo & 'hFE)) / 2;
   endfunction

   function automatic int m_read(input int a);
      int ba;
      if (a <= 5) begin
         if (a == 0 || a == 3) return m_sh[a] & 'h3F;
         if (a == 2 || a == 5) return m_sh[a] & 'hFE;
         return m_sh[a];
      end
      if (a >= 9) return 0;
      ba = m_snd * 2;
      if (a == 6) return (ba / 65536) & 'hFF;
      if (a == 7) return (ba / 256) & 'hFF;
      return ba & 'hFF;
   endfunction

   task automatic step(input bit rb, input bit on, input bit en, input bit sl,
                       input bit tk, input bit we, input int a, input int d);
      int st, en_a, nl;
      exp_t e;
      @(negedge clk);
      resb = rb; sndon = on; sndclk_en = en; sload = sl; sample_tick = tk;
      reg_we = we; reg_addr = 4'(a); reg_din = 8'(d);
      if (!rb) begin
         foreach (m_sh[i]) m_sh[i] = 0;
         m_snd = 0; m_as = 0; m_ae = 0; m_lvl = 0; m_sreq = 0; m_und = 0; m_on_d = 0;
      end else begin
         st   = byte_addr(m_sh[0], m_sh[1], m_sh[2]);
         en_a = byte_addr(m_sh[3], m_sh[4], m_sh[5]);
         m_sreq = (on && m_lvl <= 2) ? 1 : 0;
         if (on && !m_on_d) begin
            m_snd = st; m_as = st; m_ae = en_a; m_lvl = 0; m_und = 0;
         end else if (on) begin
            if (sl) begin
               m_snd = m_as; m_as = st; m_ae = en_a;
            end else if (en) begin
               m_snd = (m_snd + 1) % (1 << 21);
            end
            if (tk && !en && m_lvl == 0) m_und = 1;
            nl = m_lvl + int'(en) - int'(tk);
            m_lvl = (nl > 4) ? 4 : (nl < 0) ? 0 : nl;
         end else begin
            m_lvl = 0;
         end
         m_on_d = on;
         if (we && a <= 5) m_sh[a] = d;
      end
      e.snd = m_snd; e.sft = m_ae; e.sreq = m_sreq; e.lvl = m_lvl; e.und = m_und;
      e.dout = m_read(a);
      q.push_back(e);
   endtask

   task automatic idle(input bit on, input int a);
      step(1, on, 0, 0, 0, 0, a, 0);
   endtask

   task automatic after_edge();
      @(posedge clk); #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("snd", int'(snd), e.snd);
         chk("sft", int'(sft), e.sft);
         chk("sreq", int'(sreq), e.sreq);
         chk("fifo_level", int'(fifo_level), e.lvl);
         chk("underrun", int'(underrun), e.und);
         chk("reg_dout", int'(reg_dout), e.dout);
      end
   end

   initial begin
      resb = 0; sndon = 0; sndclk_en = 0; sload = 0; sample_tick = 0;
      reg_we = 0; reg_addr = 0; reg_din = 0;
      foreach (m_sh[i]) m_sh[i] = 0;
      m_snd = 0; m_as = 0; m_ae = 0; m_lvl = 0; m_sreq = 0; m_und = 0; m_on_d = 0;
      repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0);
      after_edge();
      chk("reset_snd", int'(snd), 0);
      chk("reset_level", int'(fifo_level), 0);

      // Program start/end and start playback.
      step(1, 0, 0, 0, 0, 1, 0, 'h01);
      step(1, 0, 0, 0, 0, 1, 1, 'h23);
      step(1, 0, 0, 0, 0, 1, 2, 'h45);
      step(1, 0, 0, 0, 0, 1, 3, 'h01);
      step(1, 0, 0, 0, 0, 1, 4, 'h23);
      step(1, 0, 0, 0, 0, 1, 5, 'h55);
      step(1, 0, 0, 0, 0, 1, 12, 'hFF);
      idle(1, 6);
      after_edge();
      chk("start_snd", int'(snd), 'h0091A2);
      chk("start_sft", int'(sft), 'h0091AA);
      chk("cnt_hi", int'(reg_dout), 'h01);
      idle(1, 7); after_edge(); chk("cnt_mid", int'(reg_dout), 'h23);
      idle(1, 8); after_edge(); chk("cnt_lo", int'(reg_dout), 'h44);

      // Three fetches without ticks.
      repeat (3) step(1, 1, 1, 0, 0, 0, 8, 0);
      after_edge();
      chk("fetch3_snd", int'(snd), 'h0091A5);
      chk("fetch3_level", int'(fifo_level), 3);
      idle(1, 0); after_edge();
      chk("fetch3_sreq", int'(sreq), 0);

      // Mid-frame end write is deferred; sload beats sndclk_en.
      step(1, 1, 0, 0, 0, 1, 5, 'h77);
      after_edge();
      chk("deferred_sft", int'(sft), 'h0091AA);
      step(1, 1, 1, 1, 0, 0, 0, 0);
      after_edge();
      chk("sload_snd", int'(snd), 'h0091A2);
      chk("sload_sft", int'(sft), 'h0091BB);

      // Wrap at the top of the address space.
      step(1, 1, 0, 0, 0, 1, 0, 'h3F);
      step(1, 1, 0, 0, 0, 1, 1, 'hFF);
      step(1, 1, 0, 0, 0, 1, 2, 'hFE);
      idle(0, 0);
      idle(1, 0); after_edge();
      chk("wrap_pre", int'(snd), 'h1FFFFF);
      step(1, 1, 1, 0, 0, 0, 0, 0); after_edge();
      chk("wrap_post", int'(snd), 0);

      // Underrun is sticky until a new playback start.
      step(1, 1, 0, 0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0, 0, 0); after_edge();
      chk("underrun_set", int'(underrun), 1);
      idle(1, 0); idle(0, 0); after_edge();
      chk("underrun_sticky", int'(underrun), 1);
      idle(1, 0); after_edge();
      chk("underrun_clear", int'(underrun), 0);

      // Reset mid-frame.
      repeat (2) step(1, 1, 1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0, 0, 0); after_edge();
      chk("rst_snd", int'(snd), 0);
      chk("rst_sft", int'(sft), 0);
      chk("rst_sreq", int'(sreq), 0);
      chk("rst_level", int'(fifo_level), 0);

      for (int i = 0; i < 1500; i++) begin
         bit on;
         on = ($urandom_range(0, 99) < 3) ? ~sndon : sndon;
         step(($urandom_range(0, 99) != 0), on, ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 255)));
      end

      repeat (3) @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/snd_dma_addr.md
SND_DMA_ADDR -- requirements
Module: snd_dma_addr

Interface
REQ-001 Port clk, input, 1: single system clock; all state updates on rising edge.
REQ-002 Port resb, input, 1: reset, synchronous and active-low, sampled on clk.
REQ-003 Port reg_we, input, 1: CPU byte-write strobe, one clk per write.
REQ-004 Port reg_addr, input, 4: register select; 0/1/2 start hi/mid/lo, 3/4/5 end hi/mid/lo, 6/7/8 counter hi/mid/lo.
REQ-005 Port reg_din, input, 8: write data.
REQ-006 Port reg_dout, output, 8: read data for reg_addr.
REQ-007 Port sndon, input, 1: playback enable, level.
REQ-008 Port sndclk_en, input, 1: one-clk pulse per sound word fetched by DMA.
REQ-009 Port sload, input, 1: one-clk frame-reload pulse from frame-end logic.
REQ-010 Port sample_tick, input, 1: one-clk pulse per sample word consumed by the DAC.
REQ-011 Port snd, output, 21: current word address [21:1].
REQ-012 Port sft, output, 21: active frame end address [21:1].
REQ-013 Port sreq, output, 1: DMA word request, registered.
REQ-014 Port fifo_level, output, 3: buffered words, 0..4.
REQ-015 Port underrun, output, 1: sticky DAC-starvation flag.

Function
REQ-016 Shadow start/end: hi byte bits [5:0] map to addr[21:16], mid to [15:8], lo bits [7:1] to [7:1]; hi bits [7:6] and lo bit 0 are ignored.
REQ-017 Register writes update shadows the clk after reg_we; writes to addr 6..15 are ignored.
REQ-018 reg_dout is combinational: shadows for 0..5, live snd for 6..8, zero for 9..15; unused bits read 0.
REQ-019 sndon rising edge is detected against a registered copy; next clk: snd <= shadow start, active start/end <= shadows, fifo_level <= 0, underrun <= 0.
REQ-020 sload pulse with sndon=1: next clk snd <= active start, then active start/end <= shadows; CPU writes during a frame take effect at the next frame.
REQ-021 sndclk_en with sndon=1 and no sload: snd <= snd+1, 21-bit modulo; 0x1FFFFF wraps to 0.
REQ-022 Priority on simultaneous events: sndon rise > sload > sndclk_en.
REQ-023 fifo_level: +1 on sndclk_en, -1 on sample_tick, unchanged when both occur; saturates at 4 and at 0.
REQ-024 sample_tick at level 0 with no simultaneous sndclk_en and sndon=1 sets underrun.
REQ-025 sreq asserts next clk when sndon=1 and fifo_level<=2; deasserts next clk when fifo_level>=3 or sndon=0.
REQ-026 sndon=0 (level): sreq 0, fifo_level held at 0, snd and sft hold their last values, sndclk_en/sload ignored.
REQ-027 sft drives the active end register.

Reset
REQ-028 resb=0 at a rising clk clears the shadows, active registers, snd, sreq, fifo_level, underrun and the sndon edge register to 0.
REQ-029 Reset mid-playback takes effect that edge; a sndon still high after reset is treated as a new rising edge.

Structure
REQ-030 Package snd_dma_pkg holds ADDR_W=21, FIFO_DEPTH=4, SREQ_THRESH=2 and register address constants.
REQ-031 One sub-module, snd_fifo_level, implements REQ-023..REQ-025; everything else lives in snd_dma_addr.

Verification
REQ-032 Write start 0x01/0x23/0x45 and end 0x01/0x23/0x55, then raise sndon -> snd=0x0091A2 and sft=0x0091AA after 1 clk; reg 6..8 read 0x01/0x23/0x44.
REQ-033 Pulse sndclk_en ×3 with no ticks -> snd +3, fifo_level 3, sreq 0 one clk after level reaches 3.
REQ-034 Assert sload and sndclk_en in the same clk -> snd equals the start address and is not incremented; a shadow end written mid-frame appears on sft only after sload.
REQ-035 With start=0x3F/0xFF/0xFE and sndon rising, pulse sndclk_en once -> snd wraps from 0x1FFFFF to 0.
REQ-036 At level 0, pulse sample_tick -> underrun=1 and stays 1; a sndon 0->1 cycle clears it; resb low mid-frame zeros all outputs on the next edge.
